// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan decoder: segment code table,
// display slot indices and bus widths.
package display_pkg;

    localparam int SEG_W = 8;
    localparam int AN_W  = 4;
    localparam int VAL_W = 7;

    localparam logic [1:0] SLOT_BOT_T = 2'd0;
    localparam logic [1:0] SLOT_BOT_U = 2'd1;
    localparam logic [1:0] SLOT_ROL_T = 2'd2;
    localparam logic [1:0] SLOT_ROL_U = 2'd3;

    // Active-high ABCDEFG pattern for each decimal digit
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment (active-high ABCDEFG) to BCD decoder; valid is low
// for any pattern that is not one of the ten digit codes.
module seg7_to_bcd
    import display_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       valid
);

    always_comb begin
        bcd   = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG_CODE[i]) begin
                bcd   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_decoder.sv
// Readback monitor for the multiplexed 7-segment display: debounces each scanned
// pattern, decodes digits and rebuilds bottles/corks. Optional DISPLAY_SCAN_ERR_CNT_EN.
module display_scan_decoder
    import display_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AN_W-1:0]  an_n,
    input  logic [SEG_W-1:0] seg_n,
    output logic [VAL_W-1:0] bottles,
    output logic [VAL_W-1:0] corks,
    output logic             frame_valid,
`ifdef DISPLAY_SCAN_ERR_CNT_EN
    output logic             seg_err,
    output logic [7:0]       err_count
`else
    output logic             seg_err
`endif
);

    function automatic logic [VAL_W-1:0] times10(input logic [3:0] x);
        logic [VAL_W-1:0] w;
        w = {3'b000, x};
        return (w << 3) + (w << 1);
    endfunction

    logic [AN_W+SEG_W-1:0] w_pins_p0;
    logic [AN_W+SEG_W-1:0] r_sample_p0;
    logic [4:0]            r_stab_p0;
    logic [4:0]            w_stab_next;
    logic                  w_accept;
    logic [AN_W-1:0]       w_an_low;
    logic                  w_blank;
    logic                  w_single;
    logic [6:0]            w_seg_ah;
    logic [3:0]            w_bcd;
    logic                  w_code_ok;
    logic [1:0]            w_slot;
    logic                  w_dig_ok;
    logic                  w_err;
    logic                  w_frame_done;
    logic [AN_W-1:0]       r_mask_p0;
    logic [3:0]            r_digit_p0 [0:3];
    logic [VAL_W-1:0]      r_bottles_p1;
    logic [VAL_W-1:0]      r_corks_p1;
    logic                  r_frame_vld_p1;
    logic                  r_seg_err_p1;

    // Stage 0: pin sampling and stability counting. The counter saturates at 16,
    // one past the largest legal STABLE_CYCLES, so a long dwell matches only once.
    always_comb begin
        w_pins_p0   = {an_n, seg_n};
        w_stab_next = 5'd1;
        if (w_pins_p0 == r_sample_p0)
            w_stab_next = (r_stab_p0 == 5'd16) ? 5'd16 : r_stab_p0 + 5'd1;
        w_accept = (w_stab_next == 5'(STABLE_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_p0 <= '1;
            r_stab_p0   <= 5'd0;
        end else begin
            r_sample_p0 <= w_pins_p0;
            r_stab_p0   <= w_stab_next;
        end
    end

    assign w_an_low = ~an_n;
    assign w_blank  = (an_n == {AN_W{1'b1}});
    assign w_single = $onehot(w_an_low);
    assign w_seg_ah = ~seg_n[7:1];

    seg7_to_bcd u_dec (
        .seg   (w_seg_ah),
        .bcd   (w_bcd),
        .valid (w_code_ok)
    );

    always_comb begin
        w_slot = SLOT_BOT_T;
        case (w_an_low)
            4'b0010: w_slot = SLOT_BOT_U;
            4'b0100: w_slot = SLOT_ROL_T;
            4'b1000: w_slot = SLOT_ROL_U;
            default: w_slot = SLOT_BOT_T;
        endcase
        w_dig_ok     = w_accept && w_single && w_code_ok;
        w_err        = w_accept && !w_blank && !(w_single && w_code_ok);
        w_frame_done = (r_mask_p0 == 4'b1111);
    end

    always_ff @(posedge clk) begin
        if (w_dig_ok)
            r_digit_p0[w_slot] <= w_bcd;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_mask_p0 <= '0;
        else if (w_err)
            r_mask_p0 <= '0;
        else
            r_mask_p0 <= (w_frame_done ? 4'b0000 : r_mask_p0) | (w_dig_ok ? w_an_low : 4'b0000);
    end

    // Stage 1: frame combiner and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bottles_p1   <= '0;
            r_corks_p1     <= '0;
            r_frame_vld_p1 <= 1'b0;
            r_seg_err_p1   <= 1'b0;
        end else begin
            r_frame_vld_p1 <= w_frame_done;
            r_seg_err_p1   <= w_err;
            if (w_frame_done) begin
                r_bottles_p1 <= times10(r_digit_p0[SLOT_BOT_T]) + {3'b000, r_digit_p0[SLOT_BOT_U]};
                r_corks_p1   <= times10(r_digit_p0[SLOT_ROL_T]) + {3'b000, r_digit_p0[SLOT_ROL_U]};
            end
        end
    end

    assign bottles     = r_bottles_p1;
    assign corks       = r_corks_p1;
    assign frame_valid = r_frame_vld_p1;
    assign seg_err     = r_seg_err_p1;

`ifdef DISPLAY_SCAN_ERR_CNT_EN
    logic [7:0] r_err_cnt_p1;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt_p1 <= 8'd0;
        else if (w_err && r_err_cnt_p1 != 8'hFF)
            r_err_cnt_p1 <= r_err_cnt_p1 + 8'd1;
    end

    assign err_count = r_err_cnt_p1;
`endif

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: table of clean frames plus glitch,
// illegal-code, multi-anode and mid-frame reset sequences.
module tb_display_scan_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic [6:0] bottles;
    logic [6:0] corks;
    logic       frame_valid;
    logic       seg_err;
`ifdef DISPLAY_SCAN_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    display_scan_decoder #(.STABLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .bottles     (bottles),
        .corks       (corks),
        .frame_valid (frame_valid),
`ifdef DISPLAY_SCAN_ERR_CNT_EN
        .seg_err     (seg_err),
        .err_count   (err_count)
`else
        .seg_err     (seg_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fv_seen  = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_seen++;
        if (seg_err === 1'b1)     err_seen++;
    end

    logic [6:0] segtab [10];

    typedef struct {
        int d0, d1, d2, d3;
        int exp_b, exp_c;
    } frame_t;

    frame_t tbl [6];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] segpat(input int d);
        return {~segtab[d], 1'b1};
    endfunction

    task automatic show(input int slot, input logic [7:0] pat, input int hold);
        an_n  = ~(4'b0001 << slot);
        seg_n = pat;
        repeat (hold) tick();
        an_n  = 4'hF;
        seg_n = 8'hFF;
        tick();
    endtask

    task automatic run_frame(input string nm, input int d0, input int d1, input int d2,
                             input int d3, input int eb, input int ec);
        int fv0, e0;
        fv0 = fv_seen;
        e0  = err_seen;
        show(0, segpat(d0), 4);
        show(1, segpat(d1), 4);
        show(2, segpat(d2), 4);
        show(3, segpat(d3), 4);
        repeat (4) tick();
        check({nm, " frame_valid pulses"}, fv_seen - fv0, 1);
        check({nm, " seg_err pulses"}, err_seen - e0, 0);
        check({nm, " bottles"}, int'(bottles), eb);
        check({nm, " corks"}, int'(corks), ec);
    endtask

    initial begin
        int fv0, e0;
        segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
        segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
        segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
        segtab[9] = 7'b1111011;

        tbl[0] = '{1, 2, 4, 7, 12, 47};
        tbl[1] = '{0, 5, 9, 9, 5, 99};
        tbl[2] = '{3, 3, 0, 0, 33, 0};
        tbl[3] = '{9, 9, 9, 9, 99, 99};
        tbl[4] = '{8, 6, 3, 1, 86, 31};
        tbl[5] = '{0, 0, 0, 0, 0, 0};

        rst   = 1'b1;
        an_n  = 4'hF;
        seg_n = 8'hFF;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset bottles", int'(bottles), 0);
            check("reset corks", int'(corks), 0);
            check("reset frame_valid", int'(frame_valid), 0);
            check("reset seg_err", int'(seg_err), 0);
`ifdef DISPLAY_SCAN_ERR_CNT_EN
            check("reset err_count", int'(err_count), 0);
`endif
        end
        rst = 1'b0;
        tick();
        check("idle frame_valid", fv_seen, 0);

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("table%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].d2,
                      tbl[i].d3, tbl[i].exp_b, tbl[i].exp_c);

        // Glitch between two clean frames
        run_frame("glitch pre", 0, 5, 9, 9, 5, 99);
        e0 = err_seen;
        show(1, segpat(8), 1);
        tick();
        check("glitch seg_err", err_seen - e0, 0);
        run_frame("glitch post", 0, 5, 9, 9, 5, 99);

        // A one-sample slot-1 glitch must not complete a three-slot frame
        fv0 = fv_seen;
        show(0, segpat(2), 4);
        show(2, segpat(6), 4);
        show(3, segpat(4), 4);
        show(1, segpat(8), 1);
        repeat (4) tick();
        check("glitch no frame", fv_seen - fv0, 0);
        show(1, segpat(1), 4);
        repeat (4) tick();
        check("glitch completes frame", fv_seen - fv0, 1);
        check("glitch completes bottles", int'(bottles), 21);
        check("glitch completes corks", int'(corks), 64);

        // Illegal segment code (only segment A lit) on slot 2 mid-frame
        fv0 = fv_seen;
        e0  = err_seen;
        show(0, segpat(3), 4);
        show(1, segpat(3), 4);
        show(2, 8'b01111111, 4);
        show(3, segpat(0), 4);
        repeat (4) tick();
        check("illegal seg_err", err_seen - e0, 1);
        check("illegal no frame", fv_seen - fv0, 0);
        check("illegal keeps bottles", int'(bottles), 21);
        run_frame("after illegal", 3, 3, 0, 0, 33, 0);

        // Two anodes low held for two samples
        e0 = err_seen;
        an_n  = 4'b0011;
        seg_n = segpat(8);
        tick();
        tick();
        an_n  = 4'hF;
        seg_n = 8'hFF;
        repeat (3) tick();
        check("multi-anode seg_err", err_seen - e0, 1);

        // Reset after slots 0 and 1 discards them
        fv0 = fv_seen;
        show(0, segpat(4), 4);
        show(1, segpat(2), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset bottles", int'(bottles), 0);
        check("midreset corks", int'(corks), 0);
        show(2, segpat(1), 4);
        show(3, segpat(1), 4);
        repeat (4) tick();
        check("midreset no frame", fv_seen - fv0, 0);
        run_frame("after midreset", 4, 2, 1, 1, 42, 11);

`ifdef DISPLAY_SCAN_ERR_CNT_EN
        check("err_count after reset", int'(err_count), 0);
        e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            an_n  = 4'b0011;
            seg_n = segpat(8);
            tick();
            tick();
            an_n  = 4'hF;
            seg_n = 8'hFF;
            tick();
        end
        repeat (2) tick();
        check("saturation seg_err pulses", err_seen - e0, 300);
        check("err_count saturated", int'(err_count), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
